// File: rtl/srv_txn_bridge_pkg.sv
// Shared types and defaults for the arbiter-to-RAM transaction bridge.
package srv_txn_bridge_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam logic [7:0] DEF_ERR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/srv_txn_bridge_sat_counter.sv
// Saturating up-counter used for the bridge statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/srv_txn_bridge.sv
// Registered rq/ack bridge from arbiter server port to RAM server,
// with response timeout and saturating statistics counters.
module srv_txn_bridge
    import srv_txn_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(DEF_ERR_DATA),
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up_rq,
    input  logic [ADDR_WIDTH-1:0] up_address,
    input  logic                  up_wr_ni,
    input  logic [DATA_WIDTH-1:0] up_dataW,
    output logic                  up_ack,
    output logic [DATA_WIDTH-1:0] up_dataR,
    output logic                  dn_rq,
    output logic [ADDR_WIDTH-1:0] dn_address,
    output logic                  dn_wr_ni,
    output logic [DATA_WIDTH-1:0] dn_dataW,
    input  logic                  dn_ack,
    input  logic [DATA_WIDTH-1:0] dn_dataR,
    input  logic                  err_clr,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  to_count
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT - 1);

    state_t                  state_q;
    logic [WCW-1:0]          wait_cnt_q;
    logic                    up_ack_q;
    logic [DATA_WIDTH-1:0]   up_dataR_q;
    logic                    dn_rq_q;
    logic [ADDR_WIDTH-1:0]   dn_address_q;
    logic                    dn_wr_ni_q;
    logic [DATA_WIDTH-1:0]   dn_dataW_q;
    logic                    err_q;

    logic ack_hit;
    logic to_hit;
    logic rd_inc;
    logic wr_inc;

    // dn_ack is only honoured while a request is outstanding.
    assign ack_hit = (state_q == WAIT) && dn_ack;
    assign to_hit  = (state_q == WAIT) && !dn_ack && (wait_cnt_q == WC_LAST);
    assign rd_inc  = ack_hit && !dn_wr_ni_q;
    assign wr_inc  = ack_hit && dn_wr_ni_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            up_ack_q     <= 1'b0;
            up_dataR_q   <= '0;
            dn_rq_q      <= 1'b0;
            dn_address_q <= '0;
            dn_wr_ni_q   <= 1'b0;
            dn_dataW_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    up_ack_q <= 1'b0;
                    if (up_rq) begin
                        dn_address_q <= up_address;
                        dn_wr_ni_q   <= up_wr_ni;
                        dn_dataW_q   <= up_dataW;
                        dn_rq_q      <= 1'b1;
                        wait_cnt_q   <= '0;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (dn_ack) begin
                        dn_rq_q  <= 1'b0;
                        up_ack_q <= 1'b1;
                        if (!dn_wr_ni_q) begin
                            up_dataR_q <= dn_dataR;
                        end
                        state_q <= RESP;
                    end else if (wait_cnt_q == WC_LAST) begin
                        dn_rq_q    <= 1'b0;
                        up_ack_q   <= 1'b1;
                        up_dataR_q <= ERR_DATA;
                        state_q    <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    up_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    up_ack_q <= 1'b0;
                    dn_rq_q  <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
            // A fresh timeout outranks a simultaneous clear.
            if (to_hit) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_rd_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i (rd_inc),
        .cnt_o (rd_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_wr_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i (wr_inc),
        .cnt_o (wr_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_to_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i (to_hit),
        .cnt_o (to_count)
    );

    assign up_ack      = up_ack_q;
    assign up_dataR    = up_dataR_q;
    assign dn_rq       = dn_rq_q;
    assign dn_address  = dn_address_q;
    assign dn_wr_ni    = dn_wr_ni_q;
    assign dn_dataW    = dn_dataW_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_srv_txn_bridge.sv
// Bench for srv_txn_bridge: vector table driven through a RAM model,
// with a response scoreboard and hand-written corner sequences.
module tb_srv_txn_bridge;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;
    localparam int CW = 3;
    localparam int NEVER = 100;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk;
    logic          reset;
    logic          up_rq;
    logic [AW-1:0] up_address;
    logic          up_wr_ni;
    logic [DW-1:0] up_dataW;
    logic          up_ack;
    logic [DW-1:0] up_dataR;
    logic          dn_rq;
    logic [AW-1:0] dn_address;
    logic          dn_wr_ni;
    logic [DW-1:0] dn_dataW;
    logic          dn_ack;
    logic [DW-1:0] dn_dataR;
    logic          err_clr;
    logic          timeout_err;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] to_count;

    srv_txn_bridge #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .ERR_DATA   (8'hFF),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .up_rq       (up_rq),
        .up_address  (up_address),
        .up_wr_ni    (up_wr_ni),
        .up_dataW    (up_dataW),
        .up_ack      (up_ack),
        .up_dataR    (up_dataR),
        .dn_rq       (dn_rq),
        .dn_address  (dn_address),
        .dn_wr_ni    (dn_wr_ni),
        .dn_dataW    (dn_dataW),
        .dn_ack      (dn_ack),
        .dn_dataR    (dn_dataR),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .to_count    (to_count)
    );

    typedef struct {
        string         name;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
        bit            clr;
    } vec_t;

    int nvec = 0;
    int nfail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data;
    logic [CW-1:0] e_rd, e_wr, e_to;
    logic          e_err;
    vec_t          tbl[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && up_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_up_ack", 32'd1, 32'd0);
            end else begin
                chk("up_dataR", 32'(up_dataR), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    task automatic chk_stats(input string tag);
        chk({tag, "_rd_count"}, 32'(rd_count), 32'(e_rd));
        chk({tag, "_wr_count"}, 32'(wr_count), 32'(e_wr));
        chk({tag, "_to_count"}, 32'(to_count), 32'(e_to));
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(e_err));
    endtask

    task automatic run_txn(input vec_t v, input bit full);
        bit   tmo;
        bit   got;
        bit   stable;
        int   ncyc;
        logic [DW-1:0] ed;
        tmo = (v.lat >= TO);
        ed  = tmo ? 8'hFF : (v.wr ? last_data : v.rdata);
        @(negedge clk);
        up_rq      = 1'b1;
        up_address = v.addr;
        up_wr_ni   = v.wr;
        up_dataW   = v.wdata;
        exp_q.push_back(ed);
        got    = 1'b0;
        stable = 1'b1;
        ncyc   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0 && full) begin
                chk({v.name, "_dn_rq_latency"}, 32'(dn_rq), 32'd1);
            end
            if (up_ack) begin
                got = 1'b1;
            end else begin
                if (dn_rq) begin
                    ncyc++;
                    if (dn_address !== v.addr || dn_wr_ni !== v.wr ||
                        dn_dataW !== v.wdata) begin
                        stable = 1'b0;
                    end
                end
                dn_ack   = dn_rq && (ncyc == v.lat + 1);
                dn_dataR = dn_ack ? v.rdata : DW'($urandom);
                err_clr  = v.clr && (ncyc == TO);
            end
        end
        dn_ack  = 1'b0;
        err_clr = 1'b0;
        up_rq   = 1'b0;
        chk({v.name, "_up_ack_seen"}, 32'(got), 32'd1);
        last_data = ed;
        if (tmo) begin
            e_to  = sat_inc(e_to);
            e_err = 1'b1;
        end else if (v.wr) begin
            e_wr = sat_inc(e_wr);
        end else begin
            e_rd = sat_inc(e_rd);
        end
        @(negedge clk);
        if (full) begin
            chk({v.name, "_dn_stable"}, 32'(stable), 32'd1);
            chk({v.name, "_dn_rq_cycles"}, 32'(ncyc),
                tmo ? 32'(TO) : 32'(v.lat + 1));
            chk({v.name, "_up_ack_width"}, 32'(up_ack), 32'd0);
            chk_stats(v.name);
        end
    endtask

    initial begin
        vec_t v;
        reset      = 1'b1;
        up_rq      = 1'b0;
        up_address = '0;
        up_wr_ni   = 1'b0;
        up_dataW   = '0;
        dn_ack     = 1'b0;
        dn_dataR   = '0;
        err_clr    = 1'b0;
        last_data  = '0;
        e_rd = '0; e_wr = '0; e_to = '0; e_err = 1'b0;

        tbl[0] = '{"rd5",      1'b0, 4'h5, 8'h00, 2,     8'h3C, 1'b0};
        tbl[1] = '{"wrA",      1'b1, 4'hA, 8'h77, 1,     8'hE1, 1'b0};
        tbl[2] = '{"rd3_fast", 1'b0, 4'h3, 8'h11, 0,     8'h5A, 1'b0};
        tbl[3] = '{"ack_edge", 1'b0, 4'h7, 8'h00, TO-1,  8'h42, 1'b0};
        tbl[4] = '{"wr1",      1'b1, 4'h1, 8'h99, 3,     8'h00, 1'b0};
        tbl[5] = '{"rd_after", 1'b0, 4'hC, 8'h00, 4,     8'hA5, 1'b0};
        tbl[6] = '{"timeout",  1'b0, 4'h9, 8'h00, NEVER, 8'h00, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_dn_rq", 32'(dn_rq), 32'd0);
        chk("rst_up_ack", 32'(up_ack), 32'd0);
        chk("rst_up_dataR", 32'(up_dataR), 32'd0);
        chk("rst_dn_bus", {dn_address, dn_wr_ni, dn_dataW}, 32'd0);
        chk_stats("rst");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], 1'b1);
        end

        // Late ack three cycles after the timeout response
        @(negedge clk);
        dn_ack   = 1'b1;
        dn_dataR = 8'h5E;
        @(negedge clk);
        dn_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_no_up_ack", 32'(up_ack), 32'd0);
            chk("late_ack_no_dn_rq", 32'(dn_rq), 32'd0);
            @(negedge clk);
        end
        chk_stats("late_ack");

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        e_err   = 1'b0;
        chk("err_clr", 32'(timeout_err), 32'd0);

        // Clear coincident with a new timeout: set must win
        v = '{"to_clr", 1'b1, 4'h2, 8'h33, NEVER, 8'h00, 1'b1};
        run_txn(v, 1'b1);

        // Reset while waiting on the RAM
        @(negedge clk);
        up_rq      = 1'b1;
        up_address = 4'h6;
        up_wr_ni   = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_dn_rq", 32'(dn_rq), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_dn_rq", 32'(dn_rq), 32'd0);
        chk("midrst_up_ack", 32'(up_ack), 32'd0);
        e_rd = '0; e_wr = '0; e_to = '0; e_err = 1'b0;
        last_data = '0;
        chk_stats("midrst");
        up_rq = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        v = '{"post_rst", 1'b0, 4'h4, 8'h00, 2, 8'hC3, 1'b0};
        run_txn(v, 1'b1);

        for (int i = 0; i < 9; i++) begin
            v = '{"sat", 1'b0, AW'(i), 8'h00, 0, DW'(i + 8'h20), 1'b0};
            run_txn(v, 1'b0);
        end
        chk("sat_rd_count", 32'(rd_count), 32'(CMAX));
        chk("sat_rd_model", 32'(e_rd), 32'(CMAX));
        chk("sat_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
